// File: rtl/ms_flood_ctrl.sv
// Minesweeper reveal sequencer: owns the open map, accepts clicks and iterates
// flood-fill expansion against the external neighbour-check block until stable.
module ms_flood_ctrl #(
    parameter int MAX_ITER = 64,
    parameter int IDX_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_game,
    input  logic             click_vld,
    input  logic [IDX_W-1:0] click_idx,
    output logic             click_rdy,
    input  logic [63:0]      mine,
    input  logic [63:0]      is_zero,
    input  logic [63:0]      flag,
    input  logic [63:0]      check,
    output logic [63:0]      open,
    output logic             busy,
    output logic             done,
    output logic             lost,
    output logic             won,
    output logic             abort
);

    localparam int CNT_W = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_END
    } state_t;

    state_t           state_q;
    logic [63:0]      open_q;
    logic             busy_q;
    logic             done_q;
    logic             lost_q;
    logic             won_q;
    logic             abort_q;
    logic [CNT_W-1:0] cnt_q;

    logic [63:0]      open_d;
    logic [63:0]      click_bit;
    logic [CNT_W-1:0] cnt_d;

    // is_zero only feeds the external check block; it is carried here for the port map.
    logic unused_is_zero;
    assign unused_is_zero = ^is_zero;

    assign click_bit = 64'd1 << click_idx;
    // Mines and flags are masked so an inconsistent check input can never open them.
    assign open_d    = open_q | (check & ~mine & ~flag);
    assign cnt_d     = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            open_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            won_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (new_game) begin
                state_q <= S_IDLE;
                open_q  <= '0;
                busy_q  <= 1'b0;
                lost_q  <= 1'b0;
                won_q   <= 1'b0;
                abort_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (click_vld) begin
                            if (flag[click_idx] || open_q[click_idx]) begin
                                done_q <= 1'b1;
                            end else if (mine[click_idx]) begin
                                open_q  <= open_q | click_bit;
                                lost_q  <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_END;
                            end else begin
                                open_q  <= open_q | click_bit;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= S_EXPAND;
                            end
                        end
                    end
                    S_EXPAND: begin
                        if (open_d == open_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            if (&(open_q | mine)) begin
                                won_q   <= 1'b1;
                                state_q <= S_END;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            open_q <= open_d;
                            cnt_q  <= cnt_d;
                            if (cnt_d == CNT_W'(MAX_ITER)) begin
                                abort_q <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_END: begin
                        state_q <= S_END;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign click_rdy = (state_q == S_IDLE);
    assign open      = open_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign lost      = lost_q;
    assign won       = won_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_ms_flood_ctrl.sv
// Bench for ms_flood_ctrl: emulates the neighbour-check block, keeps a
// snapshot-queue reference model and compares every cycle plus directed literals.
module tb_ms_flood_ctrl;

    localparam int MAX_ITER = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic        click_vld = 1'b0;
    logic [5:0]  click_idx = '0;
    logic        click_rdy;
    logic [63:0] mine = '0;
    logic [63:0] is_zero = '0;
    logic [63:0] flag = '0;
    logic [63:0] check;
    logic [63:0] open;
    logic        busy, done, lost, won, abort;

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ms_flood_ctrl #(.MAX_ITER(MAX_ITER), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .click_vld(click_vld), .click_idx(click_idx), .click_rdy(click_rdy),
        .mine(mine), .is_zero(is_zero), .flag(flag), .check(check),
        .open(open), .busy(busy), .done(done), .lost(lost), .won(won), .abort(abort)
    );

    // check[i] = OR of (open & is_zero) over the 8 neighbours of cell i
    function automatic logic [63:0] nbr_check(input logic [63:0] o, input logic [63:0] z);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int rr;
                    int cc;
                    rr = i / 8 + dr;
                    cc = i % 8 + dc;
                    if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                        if (o[rr*8+cc] && z[rr*8+cc]) r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] ring(input int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i / 8 <= d && i % 8 <= d) r[i] = 1'b1;
        return r;
    endfunction

    assign check = nbr_check(open, is_zero);

    // Reference model: on a click, the whole sequence of open maps is precomputed
    // into a queue; each expansion edge consumes one snapshot.
    logic [63:0] m_open;
    int          m_mode;   // 0 idle, 1 expanding, 2 game over
    logic        m_busy, m_done, m_lost, m_won, m_abort;
    int          m_steps;
    logic [63:0] snap_q[$];
    logic [63:0] cur_m, grow_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open <= '0; m_mode <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_lost <= 1'b0; m_won <= 1'b0; m_abort <= 1'b0; m_steps <= 0;
            snap_q.delete();
        end else begin
            m_done <= 1'b0;
            if (new_game) begin
                m_open <= '0; m_mode <= 0; m_busy <= 1'b0; m_lost <= 1'b0;
                m_won <= 1'b0; m_abort <= 1'b0; m_steps <= 0;
                snap_q.delete();
            end else if (m_mode == 0 && click_vld) begin
                if (flag[click_idx] || m_open[click_idx]) begin
                    m_done <= 1'b1;
                end else if (mine[click_idx]) begin
                    m_open <= m_open | (64'd1 << click_idx);
                    m_lost <= 1'b1; m_done <= 1'b1; m_mode <= 2;
                end else begin
                    cur_m = m_open | (64'd1 << click_idx);
                    m_open <= cur_m;
                    snap_q.delete();
                    grow_m = cur_m | (nbr_check(cur_m, is_zero) & ~mine & ~flag);
                    while (grow_m != cur_m && snap_q.size() < 200) begin
                        snap_q.push_back(grow_m);
                        cur_m  = grow_m;
                        grow_m = cur_m | (nbr_check(cur_m, is_zero) & ~mine & ~flag);
                    end
                    m_busy <= 1'b1; m_mode <= 1; m_steps <= 0;
                end
            end else if (m_mode == 1) begin
                if (snap_q.size() == 0) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    if (&(m_open | mine)) begin
                        m_won <= 1'b1; m_mode <= 2;
                    end else begin
                        m_mode <= 0;
                    end
                end else begin
                    m_open  <= snap_q.pop_front();
                    m_steps <= m_steps + 1;
                    if (m_steps + 1 == MAX_ITER) begin
                        m_abort <= 1'b1; m_busy <= 1'b0; m_done <= 1'b1; m_mode <= 0;
                        snap_q.delete();
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.open", open, m_open);
            chk("model.busy", 64'(busy), 64'(m_busy));
            chk("model.done", 64'(done), 64'(m_done));
            chk("model.lost", 64'(lost), 64'(m_lost));
            chk("model.won", 64'(won), 64'(m_won));
            chk("model.abort", 64'(abort), 64'(m_abort));
            chk("model.click_rdy", 64'(click_rdy), 64'(m_mode == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic click(input int idx);
        click_vld = 1'b1;
        click_idx = 6'(idx);
        step();
        click_vld = 1'b0;
    endtask

    task automatic start_game(input logic [63:0] mn, input logic [63:0] zr, input logic [63:0] fl);
        mine = mn; is_zero = zr; flag = fl;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        chk("reset.open", open, 64'h0);
        chk("reset.busy", 64'(busy), 64'h0);
        chk("reset.done", 64'(done), 64'h0);
        chk("reset.lost", 64'(lost), 64'h0);
        chk("reset.won", 64'(won), 64'h0);
        chk("reset.abort", 64'(abort), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("reset.rdy", 64'(click_rdy), 64'h1);

        // Test 1: empty board, full flood from the corner
        start_game('0, '1, '0);
        click(0);
        chk("t1.e0.open", open, 64'h1);
        chk("t1.e0.busy", 64'(busy), 64'h1);
        step();
        chk("t1.e1.open", open, 64'h303);
        step();
        chk("t1.e2.open", open, 64'h0707_07);
        for (int d = 3; d <= 7; d++) begin
            step();
            chk("t1.ring", open, ring(d));
            chk("t1.busy", 64'(busy), 64'h1);
        end
        chk("t1.e7.full", open, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("t1.e8.done", 64'(done), 64'h1);
        chk("t1.e8.won", 64'(won), 64'h1);
        chk("t1.e8.busy", 64'(busy), 64'h0);
        chk("t1.e8.rdy", 64'(click_rdy), 64'h0);

        // Test 2: click a mine, then a click in END is ignored
        start_game(64'h200, '1, '0);
        chk("t2.ng.open", open, 64'h0);
        click_vld = 1'b1; click_idx = 6'd9;
        step();
        click_idx = 6'd0;
        chk("t2.open", open, 64'h200);
        chk("t2.lost", 64'(lost), 64'h1);
        chk("t2.done", 64'(done), 64'h1);
        chk("t2.rdy", 64'(click_rdy), 64'h0);
        step();
        click_vld = 1'b0;
        chk("t2.ign.open", open, 64'h200);
        chk("t2.ign.done", 64'(done), 64'h0);

        // Test 5: new_game overrides a simultaneous click while in END
        new_game = 1'b1; click_vld = 1'b1; click_idx = 6'd0;
        step();
        new_game = 1'b0; click_vld = 1'b0;
        chk("t5.open", open, 64'h0);
        chk("t5.lost", 64'(lost), 64'h0);
        chk("t5.rdy", 64'(click_rdy), 64'h1);
        chk("t5.done", 64'(done), 64'h0);
        step();
        chk("t5.open2", open, 64'h0);

        // Test 3: non-zero cell opens alone
        start_game('0, ~(64'd1 << 20), '0);
        click(20);
        chk("t3.e0.open", open, 64'h0000_0000_0010_0000);
        step();
        chk("t3.e1.done", 64'(done), 64'h1);
        chk("t3.e1.rdy", 64'(click_rdy), 64'h1);
        chk("t3.e1.won", 64'(won), 64'h0);
        chk("t3.e1.open", open, 64'h0000_0000_0010_0000);

        // Test 4: all neighbours flagged, then repeat and flagged clicks are ignored
        start_game('0, '1, 64'h0000_001C_141C_0000);
        click(27);
        step();
        chk("t4.open", open, 64'h0000_0000_0800_0000);
        chk("t4.done", 64'(done), 64'h1);
        click(27);
        chk("t4.rep.done", 64'(done), 64'h1);
        chk("t4.rep.open", open, 64'h0000_0000_0800_0000);
        click(18);
        chk("t4.flag.done", 64'(done), 64'h1);
        chk("t4.flag.open", open, 64'h0000_0000_0800_0000);
        step();

        // Test 6: asynchronous reset in the middle of expansion
        start_game('0, '1, '0);
        click(0);
        step();
        step();
        step();
        chk("t6.e3.open", open, 64'h0F0F_0F0F);
        rst_n = 1'b0;
        #1;
        chk("t6.rst.open", open, 64'h0);
        chk("t6.rst.busy", 64'(busy), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6.rel.rdy", 64'(click_rdy), 64'h1);
        chk("t6.rel.open", open, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
